cva6_wbuf_merge: RTL and testbench

Parametrised write buffer between the CVA6 store unit and the data-memory request port. It supersedes the fixed-depth write-through store buffer: depth, data width and address width are configurable, and stores to the same word can optionally be combined. Entries drain in FIFO order over a valid/ready port. A combinational address check lets the load unit detect read-after-write hazards against buffered stores.

---
 rtl/cva6_wbuf_merge.sv | 122 ++++++++++++
 tb/tb_cva6_wbuf_merge.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cva6_wbuf_merge.sv
// Parametrised FIFO write buffer between the store unit and the data-memory port,
// with load-address hazard check. Optional same-word store merging: CVA6_WBUF_MERGE_EN.
module cva6_wbuf_merge #(
    parameter int unsigned XLEN       = 64,
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [XLEN-1:0]       req_data_i,
    input  logic [XLEN/8-1:0]     req_be_i,
    output logic                  mem_valid_o,
    input  logic                  mem_ready_i,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [XLEN-1:0]       mem_data_o,
    output logic [XLEN/8-1:0]     mem_be_o,
    input  logic                  flush_i,
    output logic                  empty_o,
    input  logic [ADDR_WIDTH-1:0] chk_addr_i,
    output logic                  chk_hit_o
);
    localparam int unsigned BW  = XLEN / 8;
    localparam int unsigned OFF = $clog2(BW);
    localparam int unsigned WW  = ADDR_WIDTH - OFF;
    localparam int unsigned IW  = $clog2(DEPTH);
    localparam int unsigned PW  = IW + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [PW-1:0] LAST_P  = PW'(DEPTH - 1);

    logic [DEPTH-1:0] ent_valid;
    logic [WW-1:0]    ent_waddr [DEPTH];
    logic [XLEN-1:0]  ent_data  [DEPTH];
    logic [BW-1:0]    ent_be    [DEPTH];

    logic [PW-1:0] head, tail, count;
    logic [IW-1:0] head_idx, tail_idx;
    logic [WW-1:0] req_waddr, chk_waddr;
    logic          merge, push, pop, alloc;
    logic          unused_low_bits;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_P) ? '0 : p + PW'(1);
    endfunction

    assign head_idx  = head[IW-1:0];
    assign tail_idx  = tail[IW-1:0];
    assign req_waddr = req_addr_i[ADDR_WIDTH-1:OFF];
    assign chk_waddr = chk_addr_i[ADDR_WIDTH-1:OFF];
    assign unused_low_bits = ^{req_addr_i[OFF-1:0], chk_addr_i[OFF-1:0]};

`ifdef CVA6_WBUF_MERGE_EN
    logic [IW-1:0] young_idx;
    assign young_idx = (tail == '0) ? IW'(DEPTH - 1) : IW'(tail - PW'(1));
    // The head is excluded so a presented request never changes under the memory port.
    assign merge = (count >= PW'(2)) && ent_valid[young_idx]
                && (ent_waddr[young_idx] == req_waddr) && (young_idx != head_idx);
`else
    assign merge = 1'b0;
`endif

    assign empty_o     = (count == '0);
    assign mem_valid_o = !empty_o;
    assign req_ready_o = !flush_i && ((count < DEPTH_P) || merge);
    assign push        = req_valid_i && req_ready_o;
    assign pop         = mem_valid_o && mem_ready_i;
    assign alloc       = push && !merge;

    assign mem_addr_o = mem_valid_o ? {ent_waddr[head_idx], {OFF{1'b0}}} : '0;
    assign mem_data_o = mem_valid_o ? ent_data[head_idx] : '0;
    assign mem_be_o   = mem_valid_o ? ent_be[head_idx] : '0;

    always_comb begin
        chk_hit_o = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (ent_valid[i] && (ent_waddr[i] == chk_waddr)) chk_hit_o = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            ent_valid <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_waddr[i] <= '0;
                ent_data[i]  <= '0;
                ent_be[i]    <= '0;
            end
        end else begin
            if (pop) begin
                ent_valid[head_idx] <= 1'b0;
                head                <= ptr_inc(head);
            end
`ifdef CVA6_WBUF_MERGE_EN
            if (push && merge) begin
                for (int unsigned b = 0; b < BW; b++) begin
                    if (req_be_i[b]) begin
                        ent_data[young_idx][b*8 +: 8] <= req_data_i[b*8 +: 8];
                        ent_be[young_idx][b]          <= 1'b1;
                    end
                end
            end
`endif
            if (alloc) begin
                ent_valid[tail_idx] <= 1'b1;
                ent_waddr[tail_idx] <= req_waddr;
                ent_data[tail_idx]  <= req_data_i;
                ent_be[tail_idx]    <= req_be_i;
                tail                <= ptr_inc(tail);
            end
            if (alloc && !pop) begin
                count <= count + PW'(1);
            end else if (pop && !alloc) begin
                count <= count - PW'(1);
            end
        end
    end
endmodule

// File: tb/tb_cva6_wbuf_merge.sv
// Directed self-checking bench for cva6_wbuf_merge (XLEN=64, DEPTH=8);
// merge expectations follow CVA6_WBUF_MERGE_EN.
module tb_cva6_wbuf_merge;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [63:0] req_addr = '0;
    logic [63:0] req_data = '0;
    logic [7:0]  req_be = '0;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic [63:0] mem_addr;
    logic [63:0] mem_data;
    logic [7:0]  mem_be;
    logic        flush = 1'b0;
    logic        empty;
    logic [63:0] chk_addr = '0;
    logic        chk_hit;

    int checks = 0;
    int errors = 0;

    cva6_wbuf_merge #(.XLEN(64), .ADDR_WIDTH(64), .DEPTH(8)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_addr_i(req_addr), .req_data_i(req_data), .req_be_i(req_be),
        .mem_valid_o(mem_valid), .mem_ready_i(mem_ready),
        .mem_addr_o(mem_addr), .mem_data_o(mem_data), .mem_be_o(mem_be),
        .flush_i(flush), .empty_o(empty),
        .chk_addr_i(chk_addr), .chk_hit_o(chk_hit)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [63:0] a, input logic [63:0] d, input logic [7:0] b);
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        req_be    = b;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk_addr = 64'h0;
        #1;
        checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_valid got %b exp 0", mem_valid); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", req_ready); end
        checks++; if ({mem_addr, mem_data, mem_be} !== '0) begin errors++; $display("FAIL reset_mem_bus got %h %h %h exp 0", mem_addr, mem_data, mem_be); end
        checks++; if (chk_hit !== 1'b0) begin errors++; $display("FAIL reset_chk_hit got %b exp 0", chk_hit); end
        flush = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_flush_ready got %b exp 0", req_ready); end
        flush = 1'b0;
        #1;
    endtask

    task automatic test_single();
        mem_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 64'h8000_0010;
        req_data  = 64'h1122334455667788;
        req_be    = 8'hFF;
        #1;
        checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL single_no_fallthrough got %b exp 0", mem_valid); end
        tick();
        req_valid = 1'b0;
        #1;
        checks++; if (mem_valid !== 1'b1 || empty !== 1'b0) begin errors++; $display("FAIL single_valid got v=%b e=%b exp v=1 e=0", mem_valid, empty); end
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (mem_addr !== 64'h8000_0010 || mem_data !== 64'h1122334455667788 || mem_be !== 8'hFF || mem_valid !== 1'b1) begin
                errors++; $display("FAIL single_stable cyc %0d got %h %h %h exp 80000010 1122334455667788 ff", c, mem_addr, mem_data, mem_be);
            end
            tick();
        end
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        #1;
        checks++; if (empty !== 1'b1 || mem_valid !== 1'b0) begin errors++; $display("FAIL single_pop_empty got e=%b v=%b exp e=1 v=0", empty, mem_valid); end
    endtask

    task automatic test_fill();
        int pops;
        for (int i = 0; i < 8; i++) push(64'h1000 + 64'(i * 8), 64'hD0 + 64'(i), 8'hFF);
        #1;
        checks++; if (mem_addr !== 64'h1000) begin errors++; $display("FAIL fill_head got %h exp 1000", mem_addr); end
        req_valid = 1'b1;
        req_addr  = 64'h2000;
        req_data  = 64'hEE;
        req_be    = 8'hFF;
        mem_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL fill_full_ready got %b exp 0", req_ready); end
        tick();
        req_valid = 1'b0;
        mem_ready = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_after_pop got %b exp 1", req_ready); end
        mem_ready = 1'b1;
        pops = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (mem_valid && pops < 7) begin
                checks++;
                if (mem_addr !== 64'h1000 + 64'((pops + 1) * 8) || mem_data !== 64'hD0 + 64'(pops + 1)) begin
                    errors++; $display("FAIL fill_order idx %0d got %h %h exp %h %h", pops + 1, mem_addr, mem_data,
                                       64'h1000 + 64'((pops + 1) * 8), 64'hD0 + 64'(pops + 1));
                end
            end
            if (mem_valid) pops++;
            tick();
        end
        mem_ready = 1'b0;
        checks++; if (pops !== 7) begin errors++; $display("FAIL fill_pop_count got %0d exp 7", pops); end
    endtask

    task automatic test_merge();
        logic [63:0] ea [3];
        logic [63:0] ed [3];
        logic [7:0]  eb [3];
        int n_exp;
        int pops;
        ea[0] = 64'h100; ed[0] = 64'h00000000AAAAAAAA; eb[0] = 8'h0F;
        ea[1] = 64'h200; eb[1] = 8'hFF;
`ifdef CVA6_WBUF_MERGE_EN
        n_exp = 2;
        ed[1] = 64'hBBBBBBBB22222222;
        ea[2] = 64'h0; ed[2] = 64'h0; eb[2] = 8'h0;
`else
        n_exp = 3;
        ed[1] = 64'h1111111122222222;
        ea[2] = 64'h200; ed[2] = 64'hBBBBBBBB00000000; eb[2] = 8'hF0;
`endif
        mem_ready = 1'b0;
        push(64'h100, 64'h00000000AAAAAAAA, 8'h0F);
        push(64'h200, 64'h1111111122222222, 8'hFF);
        push(64'h200, 64'hBBBBBBBB00000000, 8'hF0);
        mem_ready = 1'b1;
        pops = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (mem_valid && pops < 3) begin
                checks++;
                if (mem_addr !== ea[pops] || mem_data !== ed[pops] || mem_be !== eb[pops]) begin
                    errors++; $display("FAIL merge_entry %0d got %h %h %h exp %h %h %h", pops, mem_addr, mem_data, mem_be,
                                       ea[pops], ed[pops], eb[pops]);
                end
            end
            if (mem_valid) pops++;
            tick();
        end
        mem_ready = 1'b0;
        checks++; if (pops !== n_exp) begin errors++; $display("FAIL merge_count got %0d exp %0d", pops, n_exp); end
    endtask

    task automatic test_head_protect();
        int pops;
        mem_ready = 1'b0;
        push(64'h300, 64'hCAFE, 8'hFF);
        push(64'h300, 64'hBEEF, 8'h0F);
        #1;
        checks++; if (mem_data !== 64'hCAFE || mem_be !== 8'hFF) begin errors++; $display("FAIL head_unchanged got %h %h exp cafe ff", mem_data, mem_be); end
        mem_ready = 1'b1;
        pops = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (mem_valid && pops == 1) begin
                checks++;
                if (mem_data !== 64'hBEEF || mem_be !== 8'h0F) begin errors++; $display("FAIL head_second got %h %h exp beef 0f", mem_data, mem_be); end
            end
            if (mem_valid) pops++;
            tick();
        end
        mem_ready = 1'b0;
        checks++; if (pops !== 2) begin errors++; $display("FAIL head_alloc_count got %0d exp 2", pops); end
    endtask

    task automatic test_chk();
        mem_ready = 1'b0;
        push(64'h200, 64'h5, 8'hFF);
        chk_addr = 64'h204;
        #1;
        checks++; if (chk_hit !== 1'b1) begin errors++; $display("FAIL chk_204 got %b exp 1", chk_hit); end
        chk_addr = 64'h207;
        #1;
        checks++; if (chk_hit !== 1'b1) begin errors++; $display("FAIL chk_207 got %b exp 1", chk_hit); end
        chk_addr = 64'h210;
        #1;
        checks++; if (chk_hit !== 1'b0) begin errors++; $display("FAIL chk_210 got %b exp 0", chk_hit); end
        chk_addr = 64'h1F8;
        #1;
        checks++; if (chk_hit !== 1'b0) begin errors++; $display("FAIL chk_1f8 got %b exp 0", chk_hit); end
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk_addr = 64'h200;
        #1;
        checks++; if (chk_hit !== 1'b0) begin errors++; $display("FAIL chk_after_pop got %b exp 0", chk_hit); end
    endtask

    task automatic test_flush();
        mem_ready = 1'b0;
        push(64'h400, 64'h1, 8'hFF);
        push(64'h408, 64'h2, 8'hFF);
        push(64'h410, 64'h3, 8'hFF);
        flush     = 1'b1;
        req_valid = 1'b1;
        req_addr  = 64'h500;
        req_data  = 64'h9;
        req_be    = 8'hFF;
        mem_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL flush_ready cyc %0d got %b exp 0", c, req_ready); end
            checks++;
            if (mem_valid !== 1'b1 || mem_addr !== 64'h400 + 64'(c * 8)) begin
                errors++; $display("FAIL flush_drain cyc %0d got v=%b %h exp v=1 %h", c, mem_valid, mem_addr, 64'h400 + 64'(c * 8));
            end
            tick();
        end
        #1;
        checks++; if (empty !== 1'b1 || req_ready !== 1'b0) begin errors++; $display("FAIL flush_empty got e=%b r=%b exp e=1 r=0", empty, req_ready); end
        flush     = 1'b0;
        req_valid = 1'b0;
        mem_ready = 1'b0;
        tick();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL flush_no_accept got %b exp 1", empty); end
    endtask

    task automatic test_reset_mid();
        mem_ready = 1'b0;
        push(64'h600, 64'h6, 8'hFF);
        push(64'h608, 64'h7, 8'hFF);
        push(64'h610, 64'h8, 8'hFF);
        mem_ready = 1'b1;
        tick();
        #1;
        checks++; if (mem_addr !== 64'h608) begin errors++; $display("FAIL rstmid_drain got %h exp 608", mem_addr); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mem_ready = 1'b0;
        chk_addr = 64'h610;
        #1;
        checks++;
        if (mem_valid !== 1'b0 || empty !== 1'b1 || mem_addr !== 64'h0 || chk_hit !== 1'b0) begin
            errors++; $display("FAIL rstmid_clear got v=%b e=%b a=%h h=%b exp v=0 e=1 a=0 h=0", mem_valid, empty, mem_addr, chk_hit);
        end
        push(64'h700, 64'hA, 8'h3C);
        #1;
        checks++;
        if (mem_valid !== 1'b1 || mem_addr !== 64'h700 || mem_data !== 64'hA || mem_be !== 8'h3C) begin
            errors++; $display("FAIL rstmid_restart got v=%b %h %h %h exp v=1 700 a 3c", mem_valid, mem_addr, mem_data, mem_be);
        end
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_merge();
        test_head_protect();
        test_chk();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end
endmodule
